// File: rtl/regfile_dump_if.sv
// Bundles the register-file read port and the output word stream of the
// register dump block.
//   rf_addr   : read address toward the register file (A1)
//   rf_data   : combinational read data from the register file (RD1)
//   out_valid : a captured word is presented
//   out_ready : downstream accepts the presented word
//   out_addr  : register address of the presented word
//   out_data  : captured register value
// master = dump block, slave = register file / downstream consumer.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rf_addr, out_valid, out_addr, out_data,
    input  rf_data, out_ready
  );

  modport slave (
    input  rf_addr, out_valid, out_addr, out_data,
    output rf_data, out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks every register of a register file once, in ascending address order,
// and streams each (address, value) pair out through a valid/ready handshake.
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request a full scan (honoured only when idle)
//   abort  : synchronous cancel of a running scan
//   busy   : high whenever the block is not idle
//   done   : one-cycle pulse after the last word has been accepted
//   bus    : register-file read port and output word stream
//
// state   | meaning
// IDLE    | waiting for start
// READ    | rf_addr = idx, register file value captured at the edge
// PRESENT | captured word offered on out_*, waiting for out_ready
// FINISH  | done pulse, back to IDLE
module regfile_dump #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SKIP_R0 = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  regfile_dump_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_R0 != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  // idx only changes on entry to READ, so it doubles as the read address and
  // naturally holds its last value in every other state.
  assign bus.rf_addr   = idx;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;
  assign bus.out_data  = out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Abort wins over a handshake in the same cycle: the word is dropped.
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= FIRST_IDX;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          out_data  <= bus.rf_data;
          out_addr  <= idx;
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            // Terminate on the last address instead of wrapping idx.
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= READ;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a behavioural register file feeds two
// instances (SKIP_R0=0 and SKIP_R0=1) sharing clock and reset.
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, busy_a, done_a;
  logic start_b = 1'b0, abort_b = 1'b0, busy_b, done_b;

  logic [31:0] regs [32];

  int n_cmp = 0;
  int n_err = 0;

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  assign bus_a.rf_data = regs[bus_a.rf_addr];
  assign bus_b.rf_data = regs[bus_b.rf_addr];

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .SKIP_R0(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .bus(bus_a.master)
  );

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .SKIP_R0(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .bus(bus_b.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for dut_a to present a word.
  task automatic wait_valid_a();
    for (int i = 0; i < 20; i++) begin
      if (bus_a.out_valid) break;
      @(negedge clk);
    end
    if (!bus_a.out_valid) chk("valid_timeout", {63'd0, bus_a.out_valid}, 64'd1);
  endtask

  task automatic accept_a();
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
  endtask

  // Accepts words until the one at address a is presented (left unaccepted).
  task automatic advance_to(input logic [4:0] a);
    for (int i = 0; i < 40; i++) begin
      wait_valid_a();
      if (bus_a.out_addr == a || !bus_a.out_valid) break;
      accept_a();
    end
    chk("advance_addr", {59'd0, bus_a.out_addr}, {59'd0, a});
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    int cyc, words, n_done, done_cyc, first_addr;
    logic [4:0] nxt;
    logic seen_active;

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[5] = 32'd23;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;

    // Reset values, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs", {bus_a.out_valid, busy_a, done_a, bus_a.rf_addr, bus_a.out_addr},
        {1'b0, 1'b0, 1'b0, 5'd0, 5'd0});
    chk("rst_data", {32'd0, bus_a.out_data}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {61'd0, busy_a, bus_a.out_valid, done_a}, 64'd0);

    // Full scan with out_ready held high.
    bus_a.out_ready = 1'b1;
    pulse_start_a();
    chk("busy_in_read", {63'd0, busy_a}, 64'd1);
    cyc = 0; words = 0; n_done = 0; done_cyc = -1; nxt = 5'd0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      cyc++;
      if (bus_a.out_valid) begin
        chk("scan_addr", {59'd0, bus_a.out_addr}, {59'd0, nxt});
        chk("scan_data", {32'd0, bus_a.out_data}, (nxt == 5'd5) ? 64'd23 : 64'd0);
        words++;
        nxt = nxt + 5'd1;
      end
      if (done_a) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    chk("scan_words", 64'(words), 64'd32);
    chk("scan_done_count", 64'(n_done), 64'd1);
    chk("scan_done_cycle", 64'(done_cyc), 64'd64);
    chk("scan_end_idle", {62'd0, busy_a, bus_a.out_valid}, 64'd0);
    bus_a.out_ready = 1'b0;

    // Backpressure on word 3; start while busy must be ignored.
    regs[3] = 32'h33;
    pulse_start_a();
    advance_to(5'd3);
    for (int i = 0; i < 10; i++) begin
      start_a = (i == 2);
      @(negedge clk);
      chk("hold_word3", {23'd0, bus_a.out_valid, bus_a.out_addr, bus_a.rf_addr, bus_a.out_data},
          {23'd0, 1'b1, 5'd3, 5'd3, 32'h33});
    end
    start_a = 1'b0;
    accept_a();
    wait_valid_a();
    chk("after_hold_addr", {59'd0, bus_a.out_addr}, 64'd4);

    // Abort together with a handshake on word 7.
    advance_to(5'd7);
    bus_a.out_ready = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    bus_a.out_ready = 1'b0;
    chk("abort_idle", {61'd0, busy_a, bus_a.out_valid, done_a}, 64'd0);
    seen_active = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_active |= busy_a | bus_a.out_valid | done_a;
    end
    chk("abort_quiet", {63'd0, seen_active}, 64'd0);

    // Restart from 0; write to reg20 lands before its READ, later write does not.
    pulse_start_a();
    wait_valid_a();
    chk("restart_addr", {59'd0, bus_a.out_addr}, 64'd0);
    advance_to(5'd10);
    regs[20] = 32'hDEADBEEF;
    advance_to(5'd20);
    chk("word20_new", {32'd0, bus_a.out_data}, 64'hDEADBEEF);
    regs[20] = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    chk("word20_stable", {32'd0, bus_a.out_data}, 64'hDEADBEEF);
    accept_a();
    advance_to(5'd31);
    accept_a();
    chk("done_pulse", {62'd0, done_a, busy_a}, 64'd3);
    @(negedge clk);
    chk("done_clear", {62'd0, done_a, busy_a}, 64'd0);

    // Asynchronous reset in the middle of word 12.
    pulse_start_a();
    advance_to(5'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {bus_a.out_valid, busy_a, done_a, bus_a.rf_addr, bus_a.out_addr},
        {1'b0, 1'b0, 1'b0, 5'd0, 5'd0});
    chk("async_rst_data", {32'd0, bus_a.out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_active = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_active |= busy_a | bus_a.out_valid | done_a;
    end
    chk("post_rst_quiet", {63'd0, seen_active}, 64'd0);

    // SKIP_R0 instance: 31 words starting at 1.
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    words = 0; n_done = 0; first_addr = -1; cyc = 0; done_cyc = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      cyc++;
      if (bus_b.out_valid) begin
        if (first_addr < 0) first_addr = int'(bus_b.out_addr);
        words++;
      end
      if (done_b) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    chk("skip_first_addr", 64'(first_addr), 64'd1);
    chk("skip_words", 64'(words), 64'd31);
    chk("skip_done_count", 64'(n_done), 64'd1);
    chk("skip_done_cycle", 64'(done_cyc), 64'd62);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
